// File: rtl/rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_port_arbiter
//
// Shares the CGRA register file's single write port and single read port among
// NUM_REQ processing-element requesters. Two independent round-robin arbiters
// run every cycle. The WR arbiter sees valid write requests and the RD arbiter
// sees valid read requests, so one write and one read can be granted together.
// Read data is registered and returned with a one-hot response strobe.
//
// Optional feature macro: RF_ARB_WR_FWD_EN
//   defined   - a read and a write granted in the same cycle to the same
//               address return the write data (read-after-write).
//   undefined - the read always returns rf_dout (read-before-write).
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   data width
//   ADDR_W   register file address width
//   CNT_W    width of the saturating grant statistics counters
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_we     per-requester valid, 1 = write / 0 = read
//   req_addr/req_wdata   packed per-requester address / write data
//   req_ready            combinational grant (at most one WR + one RD bit)
//   rsp_valid/rsp_data   one-cycle one-hot read strobe, registered read data
//   rf_wen/rf_wr_addr/rf_din   register file write port
//   rf_rd_addr/rf_dout         register file read port (rf_dout combinational)
//   wr_grant_cnt/rd_grant_cnt  saturating counts of granted writes / reads
// -----------------------------------------------------------------------------
module rf_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rf_wen,
   output logic [ADDR_W-1:0]           rf_wr_addr,
   output logic [DATA_W-1:0]           rf_din,
   output logic [ADDR_W-1:0]           rf_rd_addr,
   input  logic [DATA_W-1:0]           rf_dout,
   output logic [CNT_W-1:0]            wr_grant_cnt,
   output logic [CNT_W-1:0]            rd_grant_cnt
);

   localparam int               PTR_W    = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Round-robin pick: returns {found, index} of the first set bit of elig,
   // scanning ptr, ptr+1, ... modulo NUM_REQ. The scan runs backwards so the
   // last assignment made is the lowest distance from ptr.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [PTR_W-1:0]   ptr);
      logic [PTR_W:0] res;
      int             idx;
      res = {(PTR_W+1){1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (elig[idx]) begin
            res = {1'b1, idx[PTR_W-1:0]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [NUM_REQ-1:0] rsp_valid_r;
   logic [DATA_W-1:0]  rsp_data_r;
   logic [CNT_W-1:0]   wr_cnt_r;
   logic [CNT_W-1:0]   rd_cnt_r;

   logic [NUM_REQ-1:0] wr_elig_s;
   logic [NUM_REQ-1:0] rd_elig_s;
   logic [PTR_W:0]     wr_pick_s;
   logic [PTR_W:0]     rd_pick_s;
   logic               wr_hit_s;
   logic               rd_hit_s;
   logic [PTR_W-1:0]   wr_idx_s;
   logic [PTR_W-1:0]   rd_idx_s;
   logic [ADDR_W-1:0]  wr_addr_s;
   logic [DATA_W-1:0]  wr_data_s;
   logic [ADDR_W-1:0]  rd_addr_s;
   logic [DATA_W-1:0]  rd_data_s;

   // Split requests into the two classes and run both arbiters.
   always_comb begin
      wr_elig_s = req_valid & req_we;
      rd_elig_s = req_valid & ~req_we;
      wr_pick_s = rr_pick(wr_elig_s, wr_ptr_r);
      rd_pick_s = rr_pick(rd_elig_s, rd_ptr_r);
      wr_hit_s  = wr_pick_s[PTR_W];
      rd_hit_s  = rd_pick_s[PTR_W];
      wr_idx_s  = wr_pick_s[PTR_W-1:0];
      rd_idx_s  = rd_pick_s[PTR_W-1:0];
      wr_addr_s = req_addr[wr_idx_s*ADDR_W +: ADDR_W];
      wr_data_s = req_wdata[wr_idx_s*DATA_W +: DATA_W];
      rd_addr_s = req_addr[rd_idx_s*ADDR_W +: ADDR_W];
   end

   // Select the value captured into rsp_data on a read grant.
   always_comb begin
      rd_data_s = rf_dout;
`ifdef RF_ARB_WR_FWD_EN
      // Same-cycle write to the read address: return the new data.
      if (wr_hit_s && rd_hit_s && (wr_addr_s == rd_addr_s)) begin
         rd_data_s = wr_data_s;
      end else begin
         rd_data_s = rf_dout;
      end
`endif
   end

   // Grants and register file port drive; everything is forced to zero in reset.
   always_comb begin
      req_ready  = {NUM_REQ{1'b0}};
      rf_wen     = 1'b0;
      rf_wr_addr = {ADDR_W{1'b0}};
      rf_din     = {DATA_W{1'b0}};
      rf_rd_addr = {ADDR_W{1'b0}};
      if (rst_n && wr_hit_s) begin
         req_ready[wr_idx_s] = 1'b1;
         rf_wen              = 1'b1;
         rf_wr_addr          = wr_addr_s;
         rf_din              = wr_data_s;
      end else begin
         rf_wen = 1'b0;
      end
      if (rst_n && rd_hit_s) begin
         req_ready[rd_idx_s] = 1'b1;
         rf_rd_addr          = rd_addr_s;
      end else begin
         rf_rd_addr = {ADDR_W{1'b0}};
      end
   end

   // Priority pointers: move just past the winner, wrapping to 0 after the last requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (wr_hit_s) begin
            wr_ptr_r <= (wr_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : wr_idx_s + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_hit_s) begin
            rd_ptr_r <= (rd_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : rd_idx_s + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Read response: one-cycle one-hot strobe; data holds when no read is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_data_r  <= {DATA_W{1'b0}};
      end else begin
         if (rd_hit_s) begin
            rsp_valid_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << rd_idx_s;
            rsp_data_r  <= rd_data_s;
         end else begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= rsp_data_r;
         end
      end
   end

   // Saturating grant statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_r <= {CNT_W{1'b0}};
         rd_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (wr_hit_s && (wr_cnt_r != CNT_MAX)) begin
            wr_cnt_r <= wr_cnt_r + CNT_W'(1);
         end else begin
            wr_cnt_r <= wr_cnt_r;
         end
         if (rd_hit_s && (rd_cnt_r != CNT_MAX)) begin
            rd_cnt_r <= rd_cnt_r + CNT_W'(1);
         end else begin
            rd_cnt_r <= rd_cnt_r;
         end
      end
   end

   assign rsp_valid    = rsp_valid_r;
   assign rsp_data     = rsp_data_r;
   assign wr_grant_cnt = wr_cnt_r;
   assign rd_grant_cnt = rd_cnt_r;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_port_arbiter
//
// Self-checking bench for rf_port_arbiter. A small register file stub answers
// reads and commits writes. A behavioural model predicts grants, register file
// port values, read responses and counters: the winner is the eligible
// requester with the smallest rotation distance from the pointer. Directed
// scenarios are followed by a randomized run with occasional resets.
// -----------------------------------------------------------------------------
module tb_rf_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            rf_wen;
   logic [AW-1:0]   rf_wr_addr;
   logic [DW-1:0]   rf_din;
   logic [AW-1:0]   rf_rd_addr;
   logic [DW-1:0]   rf_dout;
   logic [CW-1:0]   wr_grant_cnt;
   logic [CW-1:0]   rd_grant_cnt;

   rf_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rf_wen(rf_wen), .rf_wr_addr(rf_wr_addr), .rf_din(rf_din),
      .rf_rd_addr(rf_rd_addr), .rf_dout(rf_dout),
      .wr_grant_cnt(wr_grant_cnt), .rd_grant_cnt(rd_grant_cnt)
   );

   always #5 clk = ~clk;

   // Register file stub: entry k starts at k*10; writes commit on the edge.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          mem_init = 1'b0;
   assign rf_dout = mem[rf_rd_addr];
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int k = 0; k < (1 << AW); k++) mem[k] <= DW'(k * 10);
         mem_init <= 1'b1;
      end else if (rf_wen) begin
         mem[rf_wr_addr] <= rf_din;
      end
   end

   int total = 0;
   int bad   = 0;

   // model state
   int            m_wptr, m_rptr, m_wc, m_rc;
   logic [N-1:0]  m_rv;
   logic [DW-1:0] m_rd;
   logic [N-1:0]  pending;
   // DUT combinational outputs captured during the last step
   logic [N-1:0]  snap_ready;
   logic          snap_wen;
   logic [AW-1:0] snap_waddr, snap_raddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = eligible requester closest to ptr in rotation order, -1 if none.
   function automatic int pick(input logic [N-1:0] elig, input int ptr);
      int best, bestd, d;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         d = (i - ptr + N) % N;
         if (elig[i] && d < bestd) begin
            best  = i;
            bestd = d;
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_wptr = 0; m_rptr = 0; m_wc = 0; m_rc = 0;
      m_rv = '0; m_rd = '0; pending = '0;
   endtask

   task automatic clr();
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int i, input bit we, input int addr, input logic [DW-1:0] d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i*AW +: AW]  = AW'(addr);
      req_wdata[i*DW +: DW] = d;
   endtask

   // One clock: inputs already driven. Checks combinational outputs, advances
   // the model over the edge, then checks registered outputs at the negedge.
   task automatic step();
      int            wg, rg;
      logic [N-1:0]  er;
      logic [AW-1:0] ewa, era;
      logic [DW-1:0] ed, rv;
      wg = pick(req_valid & req_we, m_wptr);
      rg = pick(req_valid & ~req_we, m_rptr);
      er = '0; ewa = '0; era = '0; ed = '0;
      if (wg >= 0) begin
         er[wg] = 1'b1;
         ewa = req_addr[wg*AW +: AW];
         ed  = req_wdata[wg*DW +: DW];
      end
      if (rg >= 0) begin
         er[rg] = 1'b1;
         era = req_addr[rg*AW +: AW];
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rf_wen", 64'(rf_wen), 64'(wg >= 0));
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(ewa));
      chk("rf_din", 64'(rf_din), 64'(ed));
      chk("rf_rd_addr", 64'(rf_rd_addr), 64'(era));
      snap_ready = req_ready; snap_wen = rf_wen;
      snap_waddr = rf_wr_addr; snap_raddr = rf_rd_addr;
      rv = mem[era];
`ifdef RF_ARB_WR_FWD_EN
      if (wg >= 0 && rg >= 0 && ewa == era) rv = ed;
`endif
      @(posedge clk);
      if (wg >= 0) begin
         m_wptr = (wg + 1) % N;
         if (m_wc < CMAX) m_wc++;
      end
      if (rg >= 0) begin
         m_rptr = (rg + 1) % N;
         if (m_rc < CMAX) m_rc++;
         m_rv = '0;
         m_rv[rg] = 1'b1;
         m_rd = rv;
      end else begin
         m_rv = '0;
      end
      for (int i = 0; i < N; i++) pending[i] = req_valid[i] && (i != wg) && (i != rg);
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      chk("rsp_data", 64'(rsp_data), 64'(m_rd));
      chk("wr_grant_cnt", 64'(wr_grant_cnt), 64'(m_wc));
      chk("rd_grant_cnt", 64'(rd_grant_cnt), 64'(m_rc));
   endtask

   // Reset with random inputs; called at a negedge, returns just after release.
   task automatic do_reset(input int cyc);
      rst_n     = 1'b0;
      req_valid = N'($urandom);
      req_we    = N'($urandom);
      req_addr  = (N*AW)'($urandom);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_wen", 64'(rf_wen), 64'd0);
      chk("rst_wr_addr", 64'(rf_wr_addr), 64'd0);
      chk("rst_din", 64'(rf_din), 64'd0);
      chk("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_wr_cnt", 64'(wr_grant_cnt), 64'd0);
      chk("rst_rd_cnt", 64'(rd_grant_cnt), 64'd0);
      repeat (cyc) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ready", 64'(req_ready), 64'd0);
      clr();
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
   endtask

   task automatic gen_random();
      for (int i = 0; i < N; i++) begin
         if (pending[i]) begin
            if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
         end else begin
            req_valid[i] = ($urandom_range(0, 3) != 0);
            req_we[i]    = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
            req_wdata[i*DW +: DW] = $urandom;
         end
      end
   endtask

   initial begin
      clr();
      model_reset();
      @(negedge clk);
      do_reset(3);

      // Write fairness: all requesters write continuously.
      clr();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 10 + i, $urandom);
      for (int k = 0; k < 8; k++) begin
         #1;
         step();
         chk("fair_order", 64'(snap_ready), 64'(1 << (k % N)));
      end
      chk("fair_cnt", 64'(wr_grant_cnt), 64'd8);

      // Concurrent read and write to different addresses.
      clr();
      set_req(0, 1'b1, 3, 32'hAA);
      set_req(1, 1'b0, 5, 32'h0);
      #1;
      step();
      chk("conc_wen", 64'(snap_wen), 64'd1);
      chk("conc_waddr", 64'(snap_waddr), 64'd3);
      chk("conc_raddr", 64'(snap_raddr), 64'd5);
      chk("conc_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("conc_rsp_data", 64'(rsp_data), 64'd50);

      // Same-address hazard.
      clr();
      set_req(2, 1'b1, 7, 32'h55);
      set_req(3, 1'b0, 7, 32'h0);
      #1;
      step();
`ifdef RF_ARB_WR_FWD_EN
      chk("hazard_data", 64'(rsp_data), 64'h55);
`else
      chk("hazard_data", 64'(rsp_data), 64'd70);
`endif

      // Stall: bring the read pointer to 2, then req1 and req2 both read.
      clr();
      set_req(1, 1'b0, 4, 32'h0);
      #1;
      step();
      clr();
      set_req(1, 1'b0, 6, 32'h0);
      set_req(2, 1'b0, 2, 32'h0);
      #1;
      step();
      chk("stall_first", 64'(snap_ready), 64'b0100);
      req_valid[2] = 1'b0;
      #1;
      step();
      chk("stall_second", 64'(snap_ready), 64'b0010);
      chk("stall_rsp", 64'(rsp_data), 64'd60);

      // Withdraw: req0 loses to req3, then drops valid.
      clr();
      set_req(0, 1'b0, 1, 32'h0);
      set_req(3, 1'b0, 2, 32'h0);
      #1;
      step();
      chk("wd_first", 64'(snap_ready), 64'b1000);
      clr();
      #1;
      step();
      chk("wd_ready", 64'(snap_ready), 64'd0);
      chk("wd_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("wd_rd_cnt", 64'(rd_grant_cnt), 64'd6);

      // Counter saturation.
      do_reset(2);
      set_req(0, 1'b1, 9, $urandom);
      for (int k = 0; k < 20; k++) begin
         #1;
         step();
      end
      chk("sat_cnt", 64'(wr_grant_cnt), 64'd15);

      // Reset in the cycle after a read grant drops the response.
      clr();
      set_req(1, 1'b0, 5, 32'h0);
      #1;
      step();
      chk("midrd_rsp", 64'(rsp_valid), 64'b0010);
      do_reset(2);
      #1;
      step();

      // Randomized run with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) do_reset(1 + int'($urandom_range(0, 2)));
         gen_random();
         #1;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Round-robin arbiter that shares the CGRA register file's single write port and single read port among `NUM_REQ` processing-element requesters. Reads and writes are arbitrated independently each cycle, so one write and one read can be granted together. Sits between the PE request buses and the register file's `wen` / `wr_addr` / `d_in` / `rd_addr` / `d_out` pins. Returns registered read data with a one-hot response strobe.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `DATA_W`, `phit_size`: data width, taken from `my_interface.vh`.
- `ADDR_W`, `dwidth_RFadd`: register file address width.
- `CNT_W`, 16: width of the grant statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_we`  in  NUM_REQ  1 = write request, 0 = read request.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_ready`  out  NUM_REQ  grant; a transfer occurs when valid & ready.
- `rsp_valid`  out  NUM_REQ  one-hot strobe, one cycle long, marking read data for requester i.
- `rsp_data`  out  DATA_W  read data, shared by all requesters.
- `rf_wen`, `rf_wr_addr`, `rf_din`  out  1/ADDR_W/DATA_W  register file write port.
- `rf_rd_addr`  out  ADDR_W  register file read address.
- `rf_dout`  in  DATA_W  register file combinational read data.
- `wr_grant_cnt`, `rd_grant_cnt`  out  CNT_W  saturating counts of granted writes and reads.

## Operation
- There are two independent round-robin arbiters: WR over requests with `req_valid & req_we`, RD over requests with `req_valid & ~req_we`.
- Each arbiter holds a priority pointer `ptr` (0..NUM_REQ-1). It grants the first eligible requester scanning `ptr`, `ptr+1`, … modulo NUM_REQ.
- After a grant to requester g, `ptr` becomes `(g+1) mod NUM_REQ`. With no grant, `ptr` is unchanged.
- `req_ready[i]` is combinational from `req_valid`, `req_we` and `ptr`. At most one WR grant and one RD grant per cycle, so at most two bits of `req_ready` are set.
- A requester must hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until it sees `req_ready`. Dropping valid before the grant is allowed and withdraws the request.
- Write grant:
  - `rf_wen` = 1; `rf_wr_addr` and `rf_din` are muxed combinationally from the winner.
  - The register file commits the write on the same edge.
- No write grant: `rf_wen` = 0, `rf_wr_addr` = 0, `rf_din` = 0.
- Read grant:
  - `rf_rd_addr` is muxed from the winner.
  - `rf_dout` is captured into `rsp_data` at the edge.
  - `rsp_valid[g]` = 1 for the following cycle only.
- No read grant: `rf_rd_addr` = 0, `rsp_valid` = 0, and `rsp_data` holds its last value.
- A single requester cannot issue a read and a write in the same cycle; its `req_we` selects one class.
- Counters increment by 1 per granted transfer and saturate at 2^CNT_W-1.

## Timing
- Reset (asynchronous, any cycle) sets: both `ptr` = 0, `rsp_valid` = 0, `rsp_data` = 0, both counters = 0.
- Combinational outputs go to 0 while `rst_n` = 0.
- A read response in flight when reset asserts is dropped; no `rsp_valid` follows reset release.
- Write latency: data is visible in the register file one edge after the grant cycle.
- Read latency: `rsp_valid` asserts one cycle after the grant cycle. Sustained throughput is one read and one write per cycle.
- Read and write granted in the same cycle to the same address: behaviour depends on `RF_ARB_WR_FWD_EN` (see Configuration).
- Read and write in the same cycle to different addresses: fully independent.
- Pointer wrap: a grant to requester NUM_REQ-1 sets `ptr` to 0.
- With all requesters continuously valid, each class is granted in order 0,1,…,NUM_REQ-1,0.

## Configuration
- Macro `RF_ARB_WR_FWD_EN` controls same-cycle write-to-read forwarding.
- Defined: if a read and a write are granted in the same cycle with equal addresses, `rsp_data` captures the winning `req_wdata` instead of `rf_dout` (read-after-write semantics).
- Undefined: `rsp_data` always captures `rf_dout`. The read returns the pre-write value (read-before-write); no bypass logic is synthesized.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs. Expect all outputs 0 and `rsp_valid` = 0 on the first cycle after release.
- Write fairness: all 4 requesters issue writes continuously. Expect grants in order 0,1,2,3,0; `wr_grant_cnt` = 8 after 8 cycles.
- Concurrent read and write:
  - Req0 writes 0xAA to address 3 while req1 reads address 5 (holding 50) in the same cycle.
  - Expect `rf_wen` = 1 with `rf_wr_addr` = 3, and `rf_rd_addr` = 5.
  - Next cycle expect `rsp_valid` = 4'b0010 and `rsp_data` = 50.
- Same-address hazard: req2 writes 0x55 to address 7 (holding 70) while req3 reads address 7. Expect `rsp_data` = 0x55 with `RF_ARB_WR_FWD_EN`, and 70 without it.
- Stall and withdraw:
  - Req1 and req2 both request reads with `ptr` = 2. Expect req2 granted first and req1 stalled with payload held stable, then req1 granted.
  - Req0 withdrawing valid before its grant produces no transfer.
- Saturation and mid-read reset:
  - With `CNT_W` = 4, issue 20 writes. Expect `wr_grant_cnt` = 15.
  - Assert `rst_n` in the cycle after a read grant. Expect no `rsp_valid` after release.
